// File: rtl/keypad_operand_loader.sv
// ============================================================================
// keypad_operand_loader
// Debounces raw keypad presses and loads operand A then operand B over the
// shared kbd bus, raising Ready until the sequencer acknowledges the pair.
// Optional macro: ENTRY_CLEAR_EN (pulse ClearA/ClearB low in the first SETUP).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_operand_loader #(
  parameter int DEB_CYCLES   = 4,
  parameter int LATCH_CYCLES = 1
) (
  input  logic       MainClock,
  input  logic       Clear,
  input  logic [3:0] KeyCode,
  input  logic       KeyDown,
  input  logic       Ack,
  output logic [3:0] kbd,
  output logic       LatchA,
  output logic       LatchB,
  output logic       ClearA,
  output logic       ClearB,
  output logic       Sel,
  output logic       Busy,
  output logic       Ready
);

  localparam logic [3:0] DEB_N = 4'(DEB_CYCLES);
  localparam logic [2:0] LAT_N = 3'(LATCH_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_SETUP    = 3'd2,
    ST_LATCH    = 3'd3,
    ST_HOLD     = 3'd4,
    ST_RELEASE  = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic [2:0] lcnt_q, lcnt_d;
  logic [3:0] kbd_q, kbd_d;
  logic       la_q, la_d;
  logic       lb_q, lb_d;
  logic       clr_q, clr_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  always_ff @(posedge MainClock) begin
    if (Clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      cand_q  <= 4'd0;
      lcnt_q  <= 3'd0;
      kbd_q   <= 4'd0;
      la_q    <= 1'b0;
      lb_q    <= 1'b0;
      clr_q   <= 1'b1;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      lcnt_q  <= lcnt_d;
      kbd_q   <= kbd_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      clr_q   <= clr_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Outputs are computed alongside the transition so every port is registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    lcnt_d  = lcnt_q;
    kbd_d   = kbd_q;
    la_d    = la_q;
    lb_d    = lb_q;
    clr_d   = 1'b1;
    sel_d   = sel_q;
    ready_d = ready_q;

    case (state_q)
      ST_IDLE: begin
        if (KeyDown) begin
          cand_d  = KeyCode;
          cnt_d   = 4'd1;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!KeyDown || (KeyCode != cand_q)) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if ((cnt_q + 4'd1) == DEB_N) begin
          cnt_d   = 4'd0;
          kbd_d   = cand_q;
          state_d = ST_SETUP;
`ifdef ENTRY_CLEAR_EN
          clr_d   = sel_q;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SETUP: begin
        lcnt_d  = 3'd1;
        la_d    = ~sel_q;
        lb_d    = sel_q;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (lcnt_q == LAT_N) begin
          la_d    = 1'b0;
          lb_d    = 1'b0;
          state_d = ST_HOLD;
        end else begin
          lcnt_d = lcnt_q + 3'd1;
        end
      end
      ST_HOLD: begin
        kbd_d   = 4'd0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // A held key keeps restarting the release count, so it latches only once.
        if (KeyDown) begin
          cnt_d = 4'd0;
        end else if ((cnt_q + 4'd1) == DEB_N) begin
          cnt_d = 4'd0;
          if (sel_q) begin
            ready_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            sel_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (Ack) begin
          ready_d = 1'b0;
          sel_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_DEBOUNCE) || (state_d == ST_SETUP) ||
             (state_d == ST_LATCH) || (state_d == ST_HOLD) ||
             (state_d == ST_RELEASE);
  end

  assign kbd    = kbd_q;
  assign LatchA = la_q;
  assign LatchB = lb_q;
  assign ClearA = clr_q;
  assign ClearB = clr_q;
  assign Sel    = sel_q;
  assign Busy   = busy_q;
  assign Ready  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_operand_loader.sv
// ============================================================================
// tb_keypad_operand_loader
// Cycle-by-cycle vector table for keypad_operand_loader plus a held-key sequence.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_operand_loader;

  logic       MainClock = 1'b0;
  logic       Clear     = 1'b1;
  logic [3:0] KeyCode   = 4'd0;
  logic       KeyDown   = 1'b0;
  logic       Ack       = 1'b0;
  logic [3:0] kbd;
  logic       LatchA, LatchB, ClearA, ClearB, Sel, Busy, Ready;

  keypad_operand_loader #(.DEB_CYCLES(4), .LATCH_CYCLES(1)) dut (
    .MainClock(MainClock),
    .Clear    (Clear),
    .KeyCode  (KeyCode),
    .KeyDown  (KeyDown),
    .Ack      (Ack),
    .kbd      (kbd),
    .LatchA   (LatchA),
    .LatchB   (LatchB),
    .ClearA   (ClearA),
    .ClearB   (ClearB),
    .Sel      (Sel),
    .Busy     (Busy),
    .Ready    (Ready)
  );

  always #5 MainClock = ~MainClock;

  typedef struct {
    logic       clr;
    logic [3:0] code;
    logic       kd;
    logic       ack;
    logic [3:0] kbd;
    logic       la;
    logic       lb;
    logic       sel;
    logic       busy;
    logic       rdy;
    logic       s1;   // first-operand SETUP cycle
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic v(input logic clr, input logic [3:0] code, input logic kd,
                   input logic ack, input logic [3:0] ekbd, input logic la,
                   input logic lb, input logic sel, input logic busy,
                   input logic rdy, input logic s1);
    vec_t r;
    r.clr = clr; r.code = code; r.kd = kd; r.ack = ack; r.kbd = ekbd;
    r.la = la; r.lb = lb; r.sel = sel; r.busy = busy; r.rdy = rdy; r.s1 = s1;
    vq.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [11:0] act, exp;
    logic        eclr;
    int          pulses;
    int          waited;

    // Args: clr, code, kd, ack | kbd, LatchA, LatchB, Sel, Busy, Ready, firstSetup
    repeat (2) v(1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    // Clean press of 0x5, held 10 cycles
    repeat (3) v(0, 4'h5, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h5, 1, 0, 4'h5, 0, 0, 0, 1, 0, 1);
    v(0, 4'h5, 1, 0, 4'h5, 1, 0, 0, 1, 0, 0);
    v(0, 4'h5, 1, 0, 4'h5, 0, 0, 0, 1, 0, 0);
    repeat (4) v(0, 4'h5, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    repeat (3) v(0, 4'h5, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h5, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0);
    v(0, 4'h0, 0, 1, 4'h0, 0, 0, 1, 0, 0, 0);   // Ack outside DONE ignored
    // Second operand 0xA, then Ack
    repeat (3) v(0, 4'hA, 1, 0, 4'h0, 0, 0, 1, 1, 0, 0);
    v(0, 4'hA, 1, 0, 4'hA, 0, 0, 1, 1, 0, 0);
    v(0, 4'hA, 1, 0, 4'hA, 0, 1, 1, 1, 0, 0);
    v(0, 4'hA, 1, 0, 4'hA, 0, 0, 1, 1, 0, 0);
    repeat (4) v(0, 4'hA, 0, 0, 4'h0, 0, 0, 1, 1, 0, 0);
    repeat (2) v(0, 4'hA, 0, 0, 4'h0, 0, 0, 1, 0, 1, 0);
    v(0, 4'h0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0);
    v(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    // Bounce 1,0,1,1,0 on 0x3 then a stable press
    v(0, 4'h3, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h3, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    repeat (2) v(0, 4'h3, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h3, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    repeat (3) v(0, 4'h3, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h3, 1, 0, 4'h3, 0, 0, 0, 1, 0, 1);
    v(0, 4'h3, 0, 0, 4'h3, 1, 0, 0, 1, 0, 0);
    v(0, 4'h3, 0, 0, 4'h3, 0, 0, 0, 1, 0, 0);
    repeat (4) v(0, 4'h3, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h3, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0);
    v(1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    // Code change 0x2 -> 0x7 during debounce
    repeat (2) v(0, 4'h2, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h7, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    repeat (3) v(0, 4'h7, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h7, 1, 0, 4'h7, 0, 0, 0, 1, 0, 1);
    v(0, 4'h7, 0, 0, 4'h7, 1, 0, 0, 1, 0, 0);
    v(0, 4'h7, 0, 0, 4'h7, 0, 0, 0, 1, 0, 0);
    repeat (4) v(0, 4'h7, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h7, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0);
    // Clear during the LATCH cycle
    v(1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    repeat (3) v(0, 4'h9, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h9, 1, 0, 4'h9, 0, 0, 0, 1, 0, 1);
    v(0, 4'h9, 1, 0, 4'h9, 1, 0, 0, 1, 0, 0);
    v(1, 4'h9, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    v(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    // Pair 0x1 / 0x2, then keys while Ready
    repeat (3) v(0, 4'h1, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h1, 1, 0, 4'h1, 0, 0, 0, 1, 0, 1);
    v(0, 4'h1, 0, 0, 4'h1, 1, 0, 0, 1, 0, 0);
    v(0, 4'h1, 0, 0, 4'h1, 0, 0, 0, 1, 0, 0);
    repeat (4) v(0, 4'h1, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'h1, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0);
    repeat (3) v(0, 4'h2, 1, 0, 4'h0, 0, 0, 1, 1, 0, 0);
    v(0, 4'h2, 1, 0, 4'h2, 0, 0, 1, 1, 0, 0);
    v(0, 4'h2, 0, 0, 4'h2, 0, 1, 1, 1, 0, 0);
    v(0, 4'h2, 0, 0, 4'h2, 0, 0, 1, 1, 0, 0);
    repeat (4) v(0, 4'h2, 0, 0, 4'h0, 0, 0, 1, 1, 0, 0);
    v(0, 4'h2, 0, 0, 4'h0, 0, 0, 1, 0, 1, 0);
    repeat (10) v(0, 4'hF, 1, 0, 4'h0, 0, 0, 1, 0, 1, 0);
    v(0, 4'hF, 1, 1, 4'h0, 0, 0, 0, 0, 0, 0);
    repeat (3) v(0, 4'hF, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0);
    v(0, 4'hF, 1, 0, 4'hF, 0, 0, 0, 1, 0, 1);
    v(0, 4'hF, 1, 0, 4'hF, 1, 0, 0, 1, 0, 0);
    v(0, 4'hF, 1, 0, 4'hF, 0, 0, 0, 1, 0, 0);

    @(negedge MainClock);
    for (int i = 0; i < vq.size(); i++) begin
      Clear   = vq[i].clr;
      KeyCode = vq[i].code;
      KeyDown = vq[i].kd;
      Ack     = vq[i].ack;
      @(posedge MainClock);
      #1;
`ifdef ENTRY_CLEAR_EN
      eclr = ~vq[i].s1;
`else
      eclr = 1'b1;
`endif
      act = {kbd, LatchA, LatchB, Sel, Busy, Ready, ClearA, ClearB, 1'b0};
      exp = {vq[i].kbd, vq[i].la, vq[i].lb, vq[i].sel, vq[i].busy, vq[i].rdy,
             eclr, eclr, 1'b0};
      check($sformatf("row%0d{kbd,LA,LB,Sel,Busy,Rdy,ClrA,ClrB,0}", i),
            32'(act), 32'(exp));
    end

    // Key 0xF still held through RELEASE: no further latch may appear.
    pulses = 0;
    repeat (20) begin
      @(posedge MainClock);
      #1;
      if (LatchA || LatchB) pulses++;
    end
    check("held_key_extra_latch", 32'(pulses), 32'd0);
    check("held_key_busy", 32'(Busy), 32'd1);

    KeyDown = 1'b0;
    waited  = 0;
    while (Busy && waited < 12) begin
      @(posedge MainClock);
      #1;
      waited++;
    end
    check("release_timeout", 32'(Busy), 32'd0);
    check("release_wait_cycles", 32'(waited), 32'd4);
    check("sel_after_release", 32'(Sel), 32'd1);
    check("ready_after_first", 32'(Ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_operand_loader.md
Name: keypad_operand_loader

Overview:
- Keyboard-side writer for the two operand accumulators (A and B).
- Takes a raw 4-bit key code plus key-down flag, debounces it, then drives the shared kbd[3:0] bus.
- Pulses LatchA for the first accepted key and LatchB for the second.
- Raises Ready so the sequencer can start the ALU operation; waits for Ack before accepting a new operand pair.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles needed to accept a press and to accept a release (range 2..15).
- LATCH_CYCLES, 1, number of MainClock cycles LatchA/LatchB are held high (range 1..7).

Ports:
- MainClock  input  1  system clock; all state updates on rising edge.
- Clear  input  1  synchronous, active-high reset.
- KeyCode  input  4  raw key value from the keypad encoder.
- KeyDown  input  1  raw key-pressed flag; may bounce.
- Ack  input  1  sequencer has consumed the operand pair.
- kbd  output  4  operand data bus to both accumulators.
- LatchA  output  1  latch strobe to accumulator A, active-high.
- LatchB  output  1  latch strobe to accumulator B, active-high.
- ClearA  output  1  accumulator A clear, active-low.
- ClearB  output  1  accumulator B clear, active-low.
- Sel  output  1  next target: 0 = A, 1 = B.
- Busy  output  1  entry in progress.
- Ready  output  1  both operands latched.

Behaviour:
- Interface: one clock, MainClock; reset is Clear, synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, kbd=0, LatchA=LatchB=0, ClearA=ClearB=1, Sel=0, Busy=0, Ready=0, debounce counter=0, candidate=0.
- Clear mid-operation has the same effect at the next edge: any latch pulse is cut off and no partial operand is reported.
- FSM states: IDLE, DEBOUNCE, SETUP, LATCH, HOLD, RELEASE, DONE.
- Busy=1 in DEBOUNCE, SETUP, LATCH, HOLD and RELEASE; Busy=0 in IDLE and DONE.
- IDLE: if KeyDown=1, capture KeyCode as the candidate, set cnt=1, go to DEBOUNCE.
- DEBOUNCE:
  - If KeyDown=0 or KeyCode differs from the candidate: go to IDLE; no output change.
  - Otherwise cnt++.
  - When cnt reaches DEB_CYCLES: go to SETUP and load kbd with the candidate.
- SETUP: one cycle with kbd stable; go to LATCH.
- LATCH:
  - Drive LatchA if Sel=0, else LatchB, for exactly LATCH_CYCLES cycles.
  - kbd is unchanged throughout.
  - Then go to HOLD.
- HOLD: both latches low, kbd still held, one cycle; then go to RELEASE with kbd set to 0.
- RELEASE:
  - Wait for KeyDown=0 on DEB_CYCLES consecutive cycles; any KeyDown=1 restarts the count.
  - Then, if Sel=0: set Sel=1 and go to IDLE.
  - If Sel=1: set Ready=1 and go to DONE.
- DONE:
  - Keys are ignored.
  - On Ack=1: Ready=0, Sel=0, go to IDLE. If the key is still down, a new debounce starts only from IDLE on a later cycle.
- Ack outside DONE is ignored.
- A held key produces exactly one latch; it must be released before the next key is accepted.
- Timing with DEB_CYCLES=4, LATCH_CYCLES=1, KeyDown first sampled high at edge 0:
  - kbd valid from edge 3 through edge 6.
  - Latch high from edge 4 to edge 5.
  - kbd returns to 0 at edge 6.
- kbd never changes while any latch output is high.
- LatchA and LatchB are never high together.

Optional Feature:
- Macro: ENTRY_CLEAR_EN.
- Defined: in the SETUP cycle of the first operand (Sel=0), ClearA and ClearB are both driven low for exactly that one cycle, wiping both accumulators before A is latched. They are high at all other times.
- Undefined: ClearA=ClearB=1 permanently.

Test Plan:
- Reset then clean press: Clear=1 for 2 cycles; KeyCode=0x5, KeyDown=1 held 10 cycles, then 0 -> kbd=0x5 during edges 3..6; LatchA=1 for one cycle at edge 4; LatchB stays 0; Sel=1 after release debounce; Ready=0.
- Full pair: press 0x5, release, then press 0xA, release -> LatchA with kbd=0x5, then LatchB with kbd=0xA; Ready=1 after second release; Ack=1 for one cycle -> Ready=0, Sel=0, Busy=0.
- Bounce rejection: KeyDown toggles 1,0,1,1,0 with KeyCode=0x3 -> no latch pulse, kbd stays 0, state returns to IDLE; then stable for 4 cycles -> single LatchA.
- Code change during debounce: KeyCode 0x2 for 2 cycles, then 0x7 while KeyDown=1 -> first candidate dropped; 0x7 latched after 4 stable cycles from its capture.
- Mid-operation reset: assert Clear in the LATCH cycle -> at the next edge LatchA=0, kbd=0, Sel=0, Ready=0; with ENTRY_CLEAR_EN, the first SETUP shows ClearA=ClearB=0 for one cycle.
- Keys while Ready: in DONE, press 0xF for 10 cycles without Ack -> no latch; then Ack -> Ready=0, and a new debounce of 0xF starts from IDLE.
